// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_bank utility block.
// Build option: DEBOUNCE_BANK_SYNC_EN (two-flop input synchroniser).
package debounce_pkg;

  // 0.1 s at 148.5 MHz
  localparam int unsigned DEFAULT_COUNT_LIMIT = 32'd14_850_000;

  // Counter width able to hold 0..limit inclusive
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 32'd1) ? 32'd1 : 32'($clog2(limit + 32'd1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input stage, pending-change counter, clean level, edge pulses.
// DEBOUNCE_BANK_SYNC_EN selects a two-flop synchroniser ahead of the sample stage.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned COUNT_LIMIT = DEFAULT_COUNT_LIMIT,
  parameter logic        DEFAULT     = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_noisy,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_event_c
);

  localparam int unsigned     CW    = cnt_width(COUNT_LIMIT);
  localparam logic [CW-1:0]   LIMIT = CW'(COUNT_LIMIT);

  logic          r_s;
  logic          r_p;
  logic          r_clean;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_clean_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic r_meta;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= DEFAULT;
      r_s    <= DEFAULT;
    end else begin
      r_meta <= i_noisy;
      r_s    <= r_meta;
    end
  end
`else
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s <= DEFAULT;
    end else begin
      r_s <= i_noisy;
    end
  end
`endif

  // Counter only runs while a stable sample disagrees with the clean level
  always_comb begin
    w_cnt_nxt   = '0;
    w_clean_nxt = r_clean;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if ((r_s == r_p) && (r_s != r_clean)) begin
      if (r_cnt != LIMIT) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else begin
        w_clean_nxt = r_s;
        w_rise_nxt  = r_s;
        w_fall_nxt  = ~r_s;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_p     <= DEFAULT;
      r_clean <= DEFAULT;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_p     <= r_s;
      r_clean <= w_clean_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_clean   = r_clean;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_event_c = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/debounce_bank.sv
// WIDTH independent debounce channels with a registered any-edge summary.
// Define DEBOUNCE_BANK_SYNC_EN for asynchronous pins (adds a two-flop synchroniser).
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      COUNT_LIMIT = DEFAULT_COUNT_LIMIT,
  parameter logic [WIDTH-1:0] DEFAULT     = '0
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_noisy,
  output logic [WIDTH-1:0] o_clean,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any_change
);

  logic [WIDTH-1:0] w_event;
  logic             r_any_change;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_channel #(
      .COUNT_LIMIT (COUNT_LIMIT),
      .DEFAULT     (DEFAULT[gi])
    ) u_ch (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_noisy   (i_noisy[gi]),
      .o_clean   (o_clean[gi]),
      .o_rise    (o_rise[gi]),
      .o_fall    (o_fall[gi]),
      .o_event_c (w_event[gi])
    );
  end

  // Registered from the channels' next-pulse terms so it lines up with rise/fall
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |w_event;
    end
  end

  assign o_any_change = r_any_change;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer: filters WIDTH independent noisy inputs (buttons, switches, slow external strobes) into clean levels, with per-channel one-cycle rise/fall pulses. Sits between board I/O pins and the control logic in the utility library. Successor to the single-channel debouncer: adds channel count, an optional input synchroniser, edge outputs, and a counter that runs only while a change is pending.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- COUNT_LIMIT, 14850000, stable cycles required before `clean` follows (≥1; 0.1 s at 148.5 MHz)
- DEFAULT, {WIDTH{1'b0}}, reset value of `clean` and all internal input-history flops
- clock  input  1  single clock
- reset  input  1  asynchronous, active-low; low clears all state immediately
- noisy  input  WIDTH  raw asynchronous inputs, one bit per channel
- clean  output  WIDTH  debounced levels
- rise  output  WIDTH  one-cycle pulse, coincident with the cycle `clean[i]` goes 0→1
- fall  output  WIDTH  one-cycle pulse, coincident with the cycle `clean[i]` goes 1→0
- any_change  output  1  OR of `rise | fall`

## Operation
- Each channel runs independently; no shared counter.
- Per channel: sampled input `s`, previous sample `p`, counter `cnt` of CW = clog2(COUNT_LIMIT+1) bits.
- The following rules are evaluated at each edge, in priority order:
  - `s != p`: `cnt` ← 0 (input still bouncing).
  - `s == p`, `s == clean`: `cnt` ← 0 (no change pending; counter idle).
  - `s == p`, `s != clean`, `cnt != COUNT_LIMIT`: `cnt` ← `cnt`+1.
  - `s == p`, `s != clean`, `cnt == COUNT_LIMIT`: `clean` ← `s`, `cnt` ← 0, and pulse `rise` or `fall`.
- `p` ← `s` every edge.
- `rise`/`fall` are registered and high for exactly one cycle. They are never both high on one channel.
- A pulse on `s` shorter than COUNT_LIMIT+1 cycles never reaches `clean` and produces no pulses.
- Counter arithmetic never wraps. It is bounded by COUNT_LIMIT and cleared on every bounce.
- Reset (asynchronous, any time, including mid-count):
  - `clean`, `p` and the sync flops ← DEFAULT.
  - `cnt` ← 0.
  - `rise`, `fall` and `any_change` ← 0.
- After reset release, a `noisy` that differs from DEFAULT debounces normally. The first transition pulses once.

## Timing
- Edge numbering: `noisy` changes before edge 0 and is then held.
- With the synchroniser: `s` updates after edge 1. `clean` and the pulse update at edge COUNT_LIMIT+3.
- Without the synchroniser: `s` updates after edge 0. `clean` and the pulse update at edge COUNT_LIMIT+2.
- All outputs are registered, with no combinational path from `noisy`.
- `any_change` is registered together with `rise`/`fall`, in the same cycle.
- Simultaneous changes on several channels resolve independently in the same cycle.

## Configuration
- DEBOUNCE_BANK_SYNC_EN defined: two-flop synchroniser per channel ahead of `s` (metastability-safe for truly asynchronous pins).
- DEBOUNCE_BANK_SYNC_EN undefined: a single register stage forms `s`. Use this only for inputs already synchronous to `clock`. Latency is one cycle shorter.
- Ports and all other behaviour are identical in both builds.

## Structure
- Shared package `debounce_pkg`: the count-width function clog2(COUNT_LIMIT+1) and the default COUNT_LIMIT constant.
- One sub-module, `debounce_channel`: input stage, counter, `clean`, `rise` and `fall` for one bit. The top instantiates it WIDTH times via generate and ORs the pulses into `any_change`.

## Test plan
All scenarios use WIDTH=4, COUNT_LIMIT=4, DEFAULT=4'b0000, with DEBOUNCE_BANK_SYNC_EN defined.
- Reset low for 3 cycles with `noisy`=4'b1111 → `clean`=0000 and `rise`=`fall`=0 throughout. Release, hold → `clean`=1111 and `rise`=1111 for one cycle at edge 7 after release, `any_change`=1 for one cycle.
- `noisy[0]` 0→1 held → `clean[0]` rises at edge 7 exactly and `rise[0]` pulses once. It stays 1 with no further pulses for 50 cycles.
- `noisy[1]` toggles every 3 cycles for 40 cycles → `clean[1]` stays 0 and no pulses occur.
- `noisy[2]`=1 for 4 cycles, then 0 → no change on `clean[2]`. Then 1 for 10 cycles → `clean[2]` rises exactly once.
- `noisy[3]` rises, and at edge 5 reset is asserted for one cycle → `clean[3]`=0 and `cnt` cleared. After release `clean[3]` rises at edge 7 relative to release.
- Build without DEBOUNCE_BANK_SYNC_EN, `noisy[0]` 0→1 → `clean[0]` rises at edge 6.
